bulls_cows_engine: RTL

BULLS_COWS_ENGINE -- requirements
Module: bulls_cows_engine

---
 rtl/bulls_cows_pkg.sv | 20 ++
 rtl/bc_score.sv | 31 +++
 rtl/bulls_cows_engine.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/bulls_cows_pkg.sv
// Shared types and constants for the Bulls and Cows game engine.
//   digit_t     : one BCD-style digit slot (4 bits)
//   state_t     : game FSM states, encoding visible on the phase output
//   BLANK_DIGIT : marker for an unfilled buffer position
//   MAX_DIGIT   : largest digit value accepted from the switches
package bulls_cows_pkg;

  typedef logic [3:0] digit_t;

  typedef enum logic [1:0] {
    SECRET = 2'b00,
    GUESS  = 2'b01,
    SCORE  = 2'b10,
    OVER   = 2'b11
  } state_t;

  localparam digit_t BLANK_DIGIT = 4'hF;
  localparam digit_t MAX_DIGIT   = 4'd9;

endpackage

// File: rtl/bc_score.sv
// Combinational Bulls and Cows scorer.
//   secret, guess : N_DIGITS digits each, position 0 in the low nibble
//   bulls         : positions where secret and guess hold the same digit
//   cows          : digits present in both words at different positions
// Digits within one word are unique (the entry logic rejects duplicates),
// so a pairwise count gives the standard score.
module bc_score
  import bulls_cows_pkg::*;
#(
  parameter int N_DIGITS = 4
) (
  input  digit_t [N_DIGITS-1:0]          secret,
  input  digit_t [N_DIGITS-1:0]          guess,
  output logic   [$clog2(N_DIGITS+1)-1:0] bulls,
  output logic   [$clog2(N_DIGITS+1)-1:0] cows
);

  always_comb begin
    bulls = '0;
    cows  = '0;
    for (int unsigned i = 0; i < N_DIGITS; i++) begin
      for (int unsigned j = 0; j < N_DIGITS; j++) begin
        if (secret[i] == guess[j]) begin
          if (i == j) bulls = bulls + 1'b1;
          else        cows  = cows + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/bulls_cows_engine.sv
// Bulls and Cows game engine: a secret is keyed in digit by digit, then
// guesses are entered and scored until a win or MAX_TRIES guesses.
//   clock, reset   : rising-edge clock, asynchronous active-high reset
//   code           : digit value from the switches
//   enter_button   : each press commits code once
//   entry_digits   : entry buffer, position 0 in [3:0], blanks are 4'hF
//   entry_count    : digits currently held in the buffer
//   phase          : FSM state encoding
//   bulls, cows    : score of the last guess (held)
//   score_valid    : one-cycle pulse when bulls/cows update
//   tries          : guesses scored in this game
//   win, lose      : game-result levels
//   err            : one-cycle pulse on a rejected digit
// The press is captured into commit_q/code_q on the edge that samples it
// and acted upon on the following edge; scoring therefore lands two edges
// after the sampling edge of the completing press.
module bulls_cows_engine
  import bulls_cows_pkg::*;
#(
  parameter int N_DIGITS  = 4,
  parameter int MAX_TRIES = 10,
  localparam int CW = $clog2(N_DIGITS + 1)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [3:0]            code,
  input  logic                  enter_button,
  output logic [4*N_DIGITS-1:0] entry_digits,
  output logic [CW-1:0]         entry_count,
  output logic [1:0]            phase,
  output logic [CW-1:0]         bulls,
  output logic [CW-1:0]         cows,
  output logic                  score_valid,
  output logic [7:0]            tries,
  output logic                  win,
  output logic                  lose,
  output logic                  err
);

  localparam digit_t [N_DIGITS-1:0] EMPTY = {N_DIGITS{BLANK_DIGIT}};

  state_t                 state_q, state_d;
  logic                   btn_q, commit_q;
  digit_t                 code_q;
  digit_t [N_DIGITS-1:0]  entry_q, entry_d, filled;
  digit_t [N_DIGITS-1:0]  secret_q, secret_d, guess_q, guess_d;
  logic   [CW-1:0]        count_q, count_d;
  logic   [CW-1:0]        bulls_q, bulls_d, cows_q, cows_d, sc_bulls, sc_cows;
  logic   [7:0]           tries_q, tries_d, tries_inc;
  logic                   win_q, win_d, lose_q, lose_d;
  logic                   sv_q, sv_d, err_q, err_d;
  logic                   in_entry, dup, bad, write, last, win_now, lose_now;

  bc_score #(.N_DIGITS(N_DIGITS)) u_score (
    .secret (secret_q),
    .guess  (guess_q),
    .bulls  (sc_bulls),
    .cows   (sc_cows)
  );

  // Entry decode: duplicate check and the buffer with the new digit placed.
  always_comb begin
    dup    = 1'b0;
    filled = entry_q;
    for (int unsigned i = 0; i < N_DIGITS; i++) begin
      if (entry_q[i] == code_q) dup = 1'b1;
      if (count_q == CW'(i)) filled[i] = code_q;
    end
    in_entry  = commit_q && (state_q == SECRET || state_q == GUESS);
    bad       = (code_q > MAX_DIGIT) || dup;
    write     = in_entry && !bad;
    last      = write && (count_q == CW'(N_DIGITS - 1));
    tries_inc = tries_q + 8'd1;
    win_now   = (sc_bulls == CW'(N_DIGITS));
    lose_now  = (tries_inc == 8'(MAX_TRIES));
  end

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= SECRET;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      SECRET: if (last) state_d = GUESS;
      GUESS:  if (last) state_d = SCORE;
      SCORE:  state_d = (win_now || lose_now) ? OVER : GUESS;
      OVER:   if (commit_q) state_d = SECRET;
    endcase
  end

  // Datapath next values
  always_comb begin
    entry_d  = entry_q;
    count_d  = count_q;
    secret_d = secret_q;
    guess_d  = guess_q;
    bulls_d  = bulls_q;
    cows_d   = cows_q;
    tries_d  = tries_q;
    win_d    = win_q;
    lose_d   = lose_q;
    sv_d     = 1'b0;
    err_d    = in_entry && bad;
    if (write) begin
      if (last) begin
        entry_d = EMPTY;
        count_d = '0;
      end else begin
        entry_d = filled;
        count_d = count_q + 1'b1;
      end
    end
    if (state_q == SECRET && last) secret_d = filled;
    if (state_q == GUESS && last)  guess_d  = filled;
    if (state_q == SCORE) begin
      bulls_d = sc_bulls;
      cows_d  = sc_cows;
      tries_d = tries_inc;
      sv_d    = 1'b1;
      win_d   = win_now;
      lose_d  = !win_now && lose_now;
    end
    if (state_q == OVER && commit_q) begin
      entry_d  = EMPTY;
      count_d  = '0;
      secret_d = EMPTY;
      guess_d  = EMPTY;
      bulls_d  = '0;
      cows_d   = '0;
      tries_d  = '0;
      win_d    = 1'b0;
      lose_d   = 1'b0;
    end
  end

  // btn_q resets high so a button held through reset release is not a press.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      btn_q    <= 1'b1;
      commit_q <= 1'b0;
      code_q   <= '0;
      entry_q  <= EMPTY;
      count_q  <= '0;
      secret_q <= EMPTY;
      guess_q  <= EMPTY;
      bulls_q  <= '0;
      cows_q   <= '0;
      tries_q  <= '0;
      win_q    <= 1'b0;
      lose_q   <= 1'b0;
      sv_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      btn_q    <= enter_button;
      commit_q <= enter_button && !btn_q;
      code_q   <= code;
      entry_q  <= entry_d;
      count_q  <= count_d;
      secret_q <= secret_d;
      guess_q  <= guess_d;
      bulls_q  <= bulls_d;
      cows_q   <= cows_d;
      tries_q  <= tries_d;
      win_q    <= win_d;
      lose_q   <= lose_d;
      sv_q     <= sv_d;
      err_q    <= err_d;
    end
  end

  // Outputs
  always_comb begin
    phase        = state_q;
    entry_digits = entry_q;
    entry_count  = count_q;
    bulls        = bulls_q;
    cows         = cows_q;
    score_valid  = sv_q;
    tries        = tries_q;
    win          = win_q;
    lose         = lose_q;
    err          = err_q;
  end

endmodule
